// File: rtl/sha256_sched_if.sv
// sha256_sched_if -- requester and response channels of the SHA-256 job scheduler.
//   req_valid/req_ready/req_data : NREQ independent valid/ready request ports,
//                                  one 32-byte message each
//   resp_*                       : single shared valid/ready response channel,
//                                  tagged with the requester index
// slave  : the scheduler side
// master : the requesters + response consumer side
interface sha256_sched_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][31:0][7:0] req_data;

  logic                       resp_valid;
  logic                       resp_ready;
  logic [IDW-1:0]             resp_id;
  logic [31:0][7:0]           resp_res;
  logic                       resp_err;

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_res, resp_err
  );

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_res, resp_err
  );
endinterface

// File: rtl/sha256_sched.sv
// sha256_sched -- shares one SHA-256 hasher between NREQ requesters.
// Round-robin arbitration, one job in flight, timeout watchdog per job,
// shared tagged response channel.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request ports and shared response channel
//   hash_in_valid   : one-cycle start pulse to the hasher
//   hash_in_data    : message presented to the hasher
//   hash_out_valid  : hasher result pulse (only honoured while waiting)
//   hash_out_res    : hasher digest
//   busy            : scheduler is not idle
//   err_cnt         : saturating count of timed-out jobs
module sha256_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  sha256_sched_if.slave    bus,
  output logic             hash_in_valid,
  output logic [31:0][7:0] hash_in_data,
  input  logic             hash_out_valid,
  input  logic [31:0][7:0] hash_out_res,
  output logic             busy,
  output logic [15:0]      err_cnt
);
  localparam int IDW = $clog2(NREQ);
  // timer only ever holds 0..TIMEOUT-1
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             hin_valid_q, hin_valid_d;
  logic [31:0][7:0] hin_data_q, hin_data_d;
  logic             rvalid_q, rvalid_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [31:0][7:0] rres_q, rres_d;
  logic             rerr_q, rerr_d;
  logic [15:0]      errcnt_q, errcnt_d;

  // Round-robin search starting just after the last served requester.
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is held, even with requests pending.
  assign bus.req_ready = (rst_n && state_q == IDLE && found)
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << pick) : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    timer_d     = timer_q;
    hin_valid_d = 1'b0;
    hin_data_d  = hin_data_q;
    rvalid_d    = rvalid_q;
    rid_d       = rid_q;
    rres_d      = rres_q;
    rerr_d      = rerr_q;
    errcnt_d    = errcnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          hin_data_d  = bus.req_data[pick];
          grant_d     = pick;
          hin_valid_d = 1'b1;          // lands in ISSUE
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // result checked first so a same-cycle result beats the timeout
        if (hash_out_valid) begin
          rres_d   = hash_out_res;
          rerr_d   = 1'b0;
          rid_d    = grant_q;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rres_d   = '0;
          rerr_d   = 1'b1;
          rid_d    = grant_q;
          rvalid_d = 1'b1;
          errcnt_d = (errcnt_q == 16'hFFFF) ? errcnt_q : errcnt_q + 16'd1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          rvalid_d = 1'b0;
          last_d   = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      grant_q     <= '0;
      timer_q     <= '0;
      hin_valid_q <= 1'b0;
      hin_data_q  <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rres_q      <= '0;
      rerr_q      <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      hin_valid_q <= hin_valid_d;
      hin_data_q  <= hin_data_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rres_q      <= rres_d;
      rerr_q      <= rerr_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign hash_in_valid  = hin_valid_q;
  assign hash_in_data   = hin_data_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_id    = rid_q;
  assign bus.resp_res   = rres_q;
  assign bus.resp_err   = rerr_q;
  assign busy           = (state_q != IDLE);
  assign err_cnt        = errcnt_q;
endmodule

// File: tb/tb_sha256_sched.sv
// Randomised scoreboard bench for sha256_sched: a model of the round-robin
// rule predicts each grant and each response; a bench hasher answers jobs
// after a planned delay (0 = never).
module tb_sha256_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam logic [255:0] SHA0 =
    256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

  logic             clk, rst_n;
  logic             hash_in_valid, hash_out_valid, busy;
  logic [31:0][7:0] hash_in_data, hash_out_res;
  logic [15:0]      err_cnt;

  sha256_sched_if #(.NREQ(NREQ)) bus ();

  sha256_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hash_in_valid(hash_in_valid), .hash_in_data(hash_in_data),
    .hash_out_valid(hash_out_valid), .hash_out_res(hash_out_res),
    .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct {
    int           id;
    logic         err;
    logic [255:0] res;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           dq[$];
  int           n_tests = 0, n_fail = 0, cyc = 0;
  int           plan_delay = 1, m_last = NREQ - 1, stray_req = 0, stray_done = 0;
  logic         m_busy = 1'b0, issue_due = 1'b0, resp_seen = 1'b0;
  logic [255:0] issue_data = '0;
  logic [15:0]  m_errcnt = '0;
  logic [NREQ-1:0] last_acc = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [255:0] hashf(input logic [255:0] m);
    if (m == '0) return SHA0;
    return {m[127:0] ^ m[255:128], ~m[255:128]} ^ 256'h5a5a_0f0f_3c3c_1234;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Spec rule: first valid requester at last+1, last+2, ... modulo NREQ.
  function automatic logic [NREQ-1:0] rr_pick(input int last, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] r;
    r = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (r == '0 && v[(last + k) % NREQ]) r[(last + k) % NREQ] = 1'b1;
    end
    return r;
  endfunction

  // Bench hasher: answers job with planned delay d (pulse d cycles after the
  // start pulse); d == 0 never answers. Also injects stray pulses on request.
  initial begin
    int d;
    logic [255:0] m;
    hash_out_valid = 1'b0;
    hash_out_res   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) dq.delete();
      else if (hash_in_valid && dq.size() > 0) begin
        d = dq.pop_front();
        m = hash_in_data;
        if (d != 0) begin
          repeat (d) @(negedge clk);
          hash_out_valid = 1'b1;
          hash_out_res   = hashf(m);
          @(negedge clk);
          hash_out_valid = 1'b0;
        end
      end else if (stray_req != stray_done) begin
        stray_done++;
        hash_out_valid = 1'b1;
        hash_out_res   = rand256();
        @(negedge clk);
        hash_out_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    int   d, idx;
    if (!rst_n) begin
      sbq.delete();
      m_busy = 1'b0; m_last = NREQ - 1; m_errcnt = '0;
      issue_due = 1'b0; resp_seen = 1'b0; last_acc = '0;
    end else begin
      if (issue_due || hash_in_valid) chk("hash_in_valid", hash_in_valid, issue_due);
      if (issue_due) chk("hash_in_data", hash_in_data, issue_data);
      issue_due = 1'b0;
      chk("busy", busy, m_busy);
      exp_rdy = m_busy ? '0 : rr_pick(m_last, bus.req_valid);
      if (exp_rdy != '0 || bus.req_ready != '0) chk("req_ready", bus.req_ready, exp_rdy);
      last_acc = bus.req_ready & bus.req_valid;
      if (exp_rdy != '0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) idx = i;
        d     = plan_delay;
        e.id  = idx;
        e.err = (d == 0 || d > TIMEOUT);
        e.res = e.err ? '0 : hashf(bus.req_data[idx]);
        e.due = cyc + 2 + (e.err ? TIMEOUT : d);
        sbq.push_back(e);
        dq.push_back(d);
        issue_due  = 1'b1;
        issue_data = bus.req_data[idx];
        m_busy     = 1'b1;
      end
      if (!bus.resp_valid && !resp_seen && sbq.size() > 0 && cyc == sbq[0].due)
        chk("resp_late", 1, 0);
      if (bus.resp_valid) begin
        if (sbq.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = sbq[0];
          if (!resp_seen) chk("resp_latency", cyc, e.due);
          resp_seen = 1'b1;
          chk("resp_id", bus.resp_id, e.id);
          chk("resp_err", bus.resp_err, e.err);
          chk("resp_res", bus.resp_res, e.res);
          if (bus.resp_ready) begin
            void'(sbq.pop_front());
            if (e.err && m_errcnt != 16'hFFFF) m_errcnt++;
            chk("err_cnt", err_cnt, m_errcnt);
            m_last    = e.id;
            m_busy    = 1'b0;
            resp_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~last_acc;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((bus.req_valid != '0 || sbq.size() != 0 || m_busy) && n < bound) begin
      tick();
      n++;
    end
    if (bus.req_valid != '0 || sbq.size() != 0 || m_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_hash_in_valid"}, hash_in_valid, 0);
    chk({tag, "_hash_in_data"}, hash_in_data, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_id"}, bus.resp_id, 0);
    chk({tag, "_resp_res"}, bus.resp_res, 0);
    chk({tag, "_resp_err"}, bus.resp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    int raised, guard, n;
    rst_n = 1'b0;
    bus.req_valid  = '1;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single job, requester 2, 32 zero bytes
    plan_delay = 3;
    bus.req_data[2]  = '0;
    bus.req_valid[2] = 1'b1;
    wait_idle(100);

    // 2: all requesters contending, random delays (incl. timeout, race, late) and back-pressure
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i]  = rand256();
      bus.req_valid[i] = 1'b1;
    end
    raised = NREQ;
    guard  = 0;
    while (raised < 20 && guard < 4000) begin
      tick();
      guard++;
      n = $urandom_range(0, 10);
      plan_delay = (n == 10) ? 0 : n;
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && raised < 20 && $urandom_range(0, 1) == 1) begin
          bus.req_data[i]  = rand256();
          bus.req_valid[i] = 1'b1;
          raised++;
        end
      end
    end
    bus.resp_ready = 1'b1;
    wait_idle(500);

    // 3: timeout, then a normal job
    plan_delay = 0;
    bus.req_data[1] = rand256(); bus.req_valid[1] = 1'b1;
    wait_idle(100);
    plan_delay = 2;
    bus.req_data[3] = rand256(); bus.req_valid[3] = 1'b1;
    wait_idle(100);

    // 4: result on the timeout cycle; result after timeout (stray in RESP); stray in IDLE
    plan_delay = TIMEOUT;
    bus.req_data[0] = rand256(); bus.req_valid[0] = 1'b1;
    wait_idle(100);
    plan_delay = TIMEOUT + 1;
    bus.req_data[2] = rand256(); bus.req_valid[2] = 1'b1;
    wait_idle(100);
    stray_req++;
    repeat (3) tick();
    chk("idle_stray_resp_valid", bus.resp_valid, 0);
    chk("idle_stray_busy", busy, 0);

    // 5: back-pressure with requester 1 pending
    bus.resp_ready = 1'b0;
    plan_delay = 2;
    bus.req_data[0] = rand256(); bus.req_valid[0] = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 50) begin tick(); n++; end
    chk("bp_resp_valid", bus.resp_valid, 1);
    bus.req_data[1] = rand256(); bus.req_valid[1] = 1'b1;
    stray_req++;
    repeat (20) begin
      tick();
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    bus.resp_ready = 1'b1;
    wait_idle(100);

    // 6: async reset while waiting, then requester 0 wins over 3
    plan_delay = 0;
    bus.req_data[2] = rand256(); bus.req_valid[2] = 1'b1;
    n = 0;
    while (!m_busy && n < 20) begin tick(); n++; end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    plan_delay = 1;
    bus.req_data[0] = rand256();
    bus.req_data[3] = rand256();
    bus.req_valid   = 4'b1001;
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sha256_sched.md
Name: sha256_sched

Overview:
- Shares one sha256 hashing instance between NREQ requesters, each submitting a 32-byte message.
- Arbitrates round-robin and issues one job at a time to the hasher.
- Guards each job with a timeout watchdog.
- Returns the digest, or an error, on a single shared response channel tagged with the requester index.

Parameters:
- NREQ, 4: number of requesters (2..16).
- TIMEOUT, 256: cycles allowed in WAIT before the job is declared failed (≥ 2).
- IDW, $clog2(NREQ): localparam, requester-index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester job request.
- req_data  in  NREQ x [31:0][7:0]  per-requester 32-byte message.
- req_ready  out  NREQ  one-hot accept.
- hash_in_valid  out  1  one-cycle start pulse to the hasher.
- hash_in_data  out  [31:0][7:0]  message to the hasher.
- hash_out_valid  in  1  hasher result pulse.
- hash_out_res  in  [31:0][7:0]  hasher digest.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  IDW  requester index of the response.
- resp_res  out  [31:0][7:0]  digest; all zero on error.
- resp_err  out  1  1 = timeout.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  16  saturating timeout count.

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0.
  - hash_in_data 0.
  - State IDLE.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Timer 0.
- Reset mid-job abandons the job with no response. A later stray hash_out_valid is ignored, per the IDLE rule below.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i]=1, searching last_grant+1, last_grant+2, … modulo NREQ. All zeros if no request.
  - Transfer occurs when req_valid[i] & req_ready[i].
  - On transfer: capture req_data[i] into hash_in_data, capture i as grant, go to ISSUE.
  - Requesters hold valid and data stable until accepted.
- ISSUE:
  - hash_in_valid = 1 for exactly this one cycle (registered; the cycle after acceptance).
  - Clear timer, go to WAIT.
  - req_ready = 0.
- WAIT:
  - Timer increments each cycle.
  - If hash_out_valid: capture hash_out_res into resp_res, resp_err = 0, go to RESP.
  - Else if timer == TIMEOUT-1: resp_res = 0, resp_err = 1, err_cnt += 1 (saturates at 16'hFFFF), go to RESP.
  - If hash_out_valid arrives in the same cycle the timeout fires, the result wins: no error.
- RESP:
  - resp_valid = 1; resp_id = grant.
  - resp_res, resp_err, resp_id are held stable until resp_ready.
  - On resp_valid & resp_ready: last_grant = grant, resp_valid drops next cycle, go to IDLE.
  - No new request is accepted in the handshake cycle; the earliest next acceptance is the following cycle.
- hash_out_valid outside WAIT is ignored: no state change, no response.
- hash_in_data changes only on acceptance.
- busy = (state != IDLE).
- Minimum request-to-response latency:
  - Acceptance at cycle T.
  - hash_in_valid at T+1.
  - Earliest resp_valid at T+3, if hash_out_valid is at T+2.
  - In general, resp_valid follows hash_out_valid by one cycle.
- Fairness: a requester holding req_valid is granted within NREQ jobs.
- Back-pressure: resp_ready low stalls the block in RESP indefinitely. The timer does not run in RESP.

Test Plan:
1. Single job: requester 2 presents 32 zero bytes; the real sha256 hasher is attached.
   -> req_ready = 4'b0100 the same cycle; hash_in_valid one pulse at T+1.
   -> resp_valid with resp_id = 2, resp_err = 0, resp_res bit-exact equal to hash_out_res (SHA-256 of 32 zero bytes, 66687aad…0d5f2925).
2. Round-robin: all four req_valid held high, resp_ready tied 1, bench hasher returns a fixed value after 5 cycles.
   -> grants in order 0,1,2,3,0.
   -> each hash_in_valid is exactly one cycle; no two jobs overlap.
3. Timeout: TIMEOUT = 8, bench hasher never responds.
   -> resp_valid exactly 8 cycles after the ISSUE cycle's successor begins WAIT, with resp_err = 1, resp_res = 0, err_cnt = 1.
   -> the next request is accepted normally afterwards.
4. Race and stray pulses:
   -> hash_out_valid on the cycle timer = TIMEOUT-1 gives resp_err = 0 and err_cnt unchanged.
   -> a stray hash_out_valid in IDLE or RESP changes no output.
5. Back-pressure: resp_ready held low for 20 cycles with requester 1 pending.
   -> resp fields stable, req_ready = 0, busy = 1 throughout.
   -> the next grant occurs the cycle after the handshake.
6. Async reset asserted in WAIT.
   -> all outputs 0 immediately, without waiting for a clock.
   -> after release, requester 0 has priority when requesters 0 and 3 are both valid.
